// File: rtl/opb_status_bank_pkg.sv
// Shared constants and types for the OPB status bank: register offsets,
// channel accumulation modes and the bus FSM state encoding.
package opb_status_bank_pkg;

  localparam logic [31:0] REG_CTRL    = 32'h0000_0000;
  localparam logic [31:0] REG_INFO    = 32'h0000_0004;
  localparam logic [31:0] REG_CH_BASE = 32'h0000_0008;

  localparam logic [1:0] MODE_LIVE   = 2'd0;
  localparam logic [1:0] MODE_STICKY = 2'd1;
  localparam logic [1:0] MODE_PEAK   = 2'd2;

  localparam logic [15:0] INFO_ID = 16'h5342;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK,
    ST_HOLD
  } opb_state_e;

endpackage

// File: rtl/opb_status_bank_chan.sv
// One status channel: mode-dependent accumulator plus a shadow copy that
// software reads; the shadow tracks the accumulator unless frozen.
module status_chan
  import opb_status_bank_pkg::*;
#(
  parameter int         C_CH_WIDTH = 32,
  parameter logic [1:0] C_MODE     = MODE_LIVE
) (
  input  logic                  clk_sys,
  input  logic                  rst_b,
  input  logic                  valid,
  input  logic [C_CH_WIDTH-1:0] data,
  input  logic                  clear,
  input  logic                  freeze,
  output logic [C_CH_WIDTH-1:0] shadow
);

  // mode 3 is deliberately handled as live
  localparam bit IS_STICKY = (C_MODE == MODE_STICKY);
  localparam bit IS_PEAK   = (C_MODE == MODE_PEAK);

  logic [C_CH_WIDTH-1:0] acc_q, acc_base, acc_d;

  always_comb begin
    acc_base = acc_q;
    if (clear && (IS_STICKY || IS_PEAK)) acc_base = '0;
    acc_d = acc_base;
    if (valid) begin
      if (IS_STICKY)    acc_d = acc_base | data;
      else if (IS_PEAK) acc_d = (data > acc_base) ? data : acc_base;
      else              acc_d = data;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      acc_q  <= '0;
      shadow <= '0;
    end else begin
      acc_q <= acc_d;
      if (!freeze) shadow <= acc_q;
    end
  end

endmodule

// File: rtl/opb_status_bank.sv
// OPB slave exposing C_NUM_CH accumulated user status channels with a
// software-controlled freeze/clear, plus an identification register.
//
// state   | meaning
// IDLE    | waiting for an in-range OPB select
// ACK     | Sl_xferAck high, read data on Sl_DBus, write commits at the edge
// HOLD    | one dead cycle so the master can drop select
module opb_status_bank
  import opb_status_bank_pkg::*;
#(
  parameter logic [31:0]           C_BASEADDR   = 32'h0108_0600,
  parameter logic [31:0]           C_HIGHADDR   = 32'h0108_06FF,
  parameter int                    C_OPB_AWIDTH = 32,
  parameter int                    C_OPB_DWIDTH = 32,
  parameter int                    C_NUM_CH     = 8,
  parameter int                    C_CH_WIDTH   = 32,
  parameter logic [2*C_NUM_CH-1:0] C_CH_MODE    = '0,
  parameter string                 C_FAMILY     = "virtex5"
) (
  input  logic                             OPB_Clk,
  input  logic                             OPB_Rst_n,
  output logic [0:C_OPB_DWIDTH-1]          Sl_DBus,
  output logic                             Sl_errAck,
  output logic                             Sl_retry,
  output logic                             Sl_toutSup,
  output logic                             Sl_xferAck,
  input  logic [0:C_OPB_AWIDTH-1]          OPB_ABus,
  input  logic [0:3]                       OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]          OPB_DBus,
  input  logic                             OPB_RNW,
  input  logic                             OPB_select,
  input  logic                             OPB_seqAddr,
  input  logic [C_NUM_CH*C_CH_WIDTH-1:0]   user_data_in,
  input  logic [C_NUM_CH-1:0]              user_valid,
  output logic                             user_frozen
);

  opb_state_e state_q, state_d;

  logic [31:0]             addr, ofs;
  logic                    addr_hit;
  logic [29:0]             wofs_q;
  logic                    rnw_q, be3_q;
  logic [1:0]              wbits_q;
  logic                    freeze_q, clear_q;
  logic [C_OPB_DWIDTH-1:0] rd_data;
  logic [C_NUM_CH*C_CH_WIDTH-1:0] shadow;

  assign addr     = 32'(OPB_ABus);
  assign addr_hit = (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
  assign ofs      = addr - C_BASEADDR;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (OPB_select && addr_hit) state_d = ST_ACK;
      ST_ACK:  state_d = ST_HOLD;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      state_q  <= ST_IDLE;
      wofs_q   <= '0;
      rnw_q    <= 1'b1;
      be3_q    <= 1'b0;
      wbits_q  <= '0;
      freeze_q <= 1'b0;
      clear_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      clear_q <= 1'b0;
      if (state_q == ST_IDLE && state_d == ST_ACK) begin
        wofs_q  <= ofs[31:2];
        rnw_q   <= OPB_RNW;
        be3_q   <= OPB_BE[3];
        wbits_q <= {OPB_DBus[C_OPB_DWIDTH-2], OPB_DBus[C_OPB_DWIDTH-1]};
      end
      // CLEAR is a one-cycle pulse landing in the HOLD cycle
      if (state_q == ST_ACK && !rnw_q && be3_q && wofs_q == REG_CTRL[31:2]) begin
        freeze_q <= wbits_q[0];
        clear_q  <= wbits_q[1];
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (wofs_q == REG_CTRL[31:2]) begin
      rd_data[0] = freeze_q;
    end else if (wofs_q == REG_INFO[31:2]) begin
      rd_data[31:16] = INFO_ID;
      rd_data[15:8]  = 8'(C_CH_WIDTH);
      rd_data[7:0]   = 8'(C_NUM_CH);
    end else begin
      for (int i = 0; i < C_NUM_CH; i++) begin
        if (wofs_q == REG_CH_BASE[31:2] + 30'(i))
          rd_data[C_CH_WIDTH-1:0] = shadow[i*C_CH_WIDTH +: C_CH_WIDTH];
      end
    end
  end

  for (genvar i = 0; i < C_NUM_CH; i++) begin : g_ch
    status_chan #(
      .C_CH_WIDTH (C_CH_WIDTH),
      .C_MODE     (C_CH_MODE[2*i +: 2])
    ) u_chan (
      .clk_sys (OPB_Clk),
      .rst_b   (OPB_Rst_n),
      .valid   (user_valid[i]),
      .data    (user_data_in[i*C_CH_WIDTH +: C_CH_WIDTH]),
      .clear   (clear_q),
      .freeze  (freeze_q),
      .shadow  (shadow[i*C_CH_WIDTH +: C_CH_WIDTH])
    );
  end

  assign Sl_xferAck  = (state_q == ST_ACK);
  assign Sl_DBus     = (state_q == ST_ACK && rnw_q) ? rd_data : '0;
  assign Sl_errAck   = 1'b0;
  assign Sl_retry    = 1'b0;
  assign Sl_toutSup  = 1'b0;
  assign user_frozen = freeze_q;

  logic unused_bits;
  assign unused_bits = ^{OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:C_OPB_DWIDTH-3], ofs[1:0],
                         (C_FAMILY == "")};

endmodule

// File: tb/tb_opb_status_bank.sv
// Directed bench for opb_status_bank: a default-sized bank (ch0 live, ch1
// sticky, ch2 peak) plus an 8-bit single-channel peak bank on the same bus.
module tb_opb_status_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:31] abus, dbus_w;
  logic [0:3]  be_s;
  logic        rnw_s, sel, seq;

  logic [0:31] a_dbus, b_dbus;
  logic        a_ack, b_ack, a_err, b_err, a_retry, b_retry, a_tout, b_tout;
  logic        frozen_a, frozen_b;
  logic [255:0] data_a;
  logic [7:0]   valid_a;
  logic [7:0]   data_b;
  logic [0:0]   valid_b;

  logic        ack;
  logic [31:0] dbus_r;
  assign ack    = a_ack | b_ack;
  assign dbus_r = 32'(a_dbus | b_dbus);

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  opb_status_bank #(
    .C_CH_MODE (16'h0024)
  ) dut_a (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .Sl_DBus(a_dbus), .Sl_errAck(a_err),
    .Sl_retry(a_retry), .Sl_toutSup(a_tout), .Sl_xferAck(a_ack),
    .OPB_ABus(abus), .OPB_BE(be_s), .OPB_DBus(dbus_w), .OPB_RNW(rnw_s),
    .OPB_select(sel), .OPB_seqAddr(seq), .user_data_in(data_a),
    .user_valid(valid_a), .user_frozen(frozen_a)
  );

  opb_status_bank #(
    .C_BASEADDR (32'h0108_0800),
    .C_HIGHADDR (32'h0108_08FF),
    .C_NUM_CH   (1),
    .C_CH_WIDTH (8),
    .C_CH_MODE  (2'b10)
  ) dut_b (
    .OPB_Clk(clk), .OPB_Rst_n(rst_n), .Sl_DBus(b_dbus), .Sl_errAck(b_err),
    .Sl_retry(b_retry), .Sl_toutSup(b_tout), .Sl_xferAck(b_ack),
    .OPB_ABus(abus), .OPB_BE(be_s), .OPB_DBus(dbus_w), .OPB_RNW(rnw_s),
    .OPB_select(sel), .OPB_seqAddr(seq), .user_data_in(data_b),
    .user_valid(valid_b), .user_frozen(frozen_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus transfer; returns read data, edges from select to ack, and ack cycles seen.
  task automatic opb_access(input logic [31:0] addr, input logic rnw, input logic [31:0] wdata,
                            input logic [3:0] be, output logic [31:0] rdata,
                            output int lat, output int acks);
    @(posedge clk); #1;
    abus = addr; rnw_s = rnw; dbus_w = wdata; be_s = be; sel = 1'b1;
    lat = -1; rdata = 32'hDEAD_BEEF; acks = 0;
    for (int c = 1; c <= 8 && lat < 0; c++) begin
      @(posedge clk); #1;
      if (ack) begin lat = c; rdata = dbus_r; acks++; end
    end
    sel = 1'b0; rnw_s = 1'b1;
    @(posedge clk); #1;
    if (ack) acks++;
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d; int l, a;
    opb_access(addr, 1'b1, 32'h0, 4'hF, d, l, a);
    chk(tag, d, exp);
    chk({tag, "_acks"}, 32'(a), 32'd1);
  endtask

  task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] d; int l, a;
    opb_access(addr, 1'b0, wd, be, d, l, a);
    chk({tag, "_acks"}, 32'(a), 32'd1);
  endtask

  task automatic pulse_a(input int ch, input logic [31:0] val);
    @(posedge clk); #1;
    data_a[ch*32 +: 32] = val; valid_a[ch] = 1'b1;
    @(posedge clk); #1;
    valid_a = '0;
  endtask

  task automatic pulse_b(input logic [7:0] val);
    @(posedge clk); #1;
    data_b = val; valid_b = 1'b1;
    @(posedge clk); #1;
    valid_b = '0;
  endtask

  initial begin
    logic [31:0] d;
    int l, a;
    rst_n = 1'b0; abus = '0; dbus_w = '0; be_s = '0; rnw_s = 1'b1; sel = 1'b0; seq = 1'b0;
    data_a = '0; valid_a = '0; data_b = '0; valid_b = '0;
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_dbus", dbus_r, 32'h0);
    chk("rst_frozen", 32'(frozen_a), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // INFO, latency and single-cycle ack
    opb_access(32'h0108_0604, 1'b1, 32'h0, 4'hF, d, l, a);
    chk("info_a", d, 32'h5342_2008);
    chk("info_lat", 32'(l), 32'd1);
    chk("info_acks", 32'(a), 32'd1);
    chk("idle_dbus", dbus_r, 32'h0);
    rd("info_b", 32'h0108_0804, 32'h5342_0801);

    // live channel
    pulse_a(0, 32'h11);
    pulse_a(0, 32'h22);
    rd("ch0_live", 32'h0108_0608, 32'h22);

    // sticky channel and CLEAR
    pulse_a(1, 32'h01);
    pulse_a(1, 32'h80);
    rd("ch1_sticky", 32'h0108_060C, 32'h81);
    wr("clr", 32'h0108_0600, 32'h2, 4'hF);
    rd("ch1_cleared", 32'h0108_060C, 32'h0);
    rd("ctrl_clr_reads0", 32'h0108_0600, 32'h0);
    rd("ch0_live_keeps", 32'h0108_0608, 32'h22);
    pulse_a(1, 32'h10);
    wr("clr2", 32'h0108_0600, 32'h2, 4'hF);
    // wr returns inside the CLEAR cycle; a valid here lands on zero
    data_a[32 +: 32] = 32'h04; valid_a[1] = 1'b1;
    @(posedge clk); #1 valid_a = '0;
    rd("ch1_clr_same_cycle", 32'h0108_060C, 32'h04);

    // peak channel
    pulse_a(2, 32'd5);
    pulse_a(2, 32'd9);
    pulse_a(2, 32'd3);
    rd("ch2_peak", 32'h0108_0610, 32'd9);
    pulse_b(8'hFF);
    pulse_b(8'h10);
    rd("b_ch0_zext", 32'h0108_0808, 32'h0000_00FF);

    // freeze
    wr("frz", 32'h0108_0600, 32'h1, 4'hF);
    chk("frozen_1", 32'(frozen_a), 32'd1);
    pulse_a(0, 32'h55);
    rd("ch0_frozen", 32'h0108_0608, 32'h22);
    rd("ctrl_frz", 32'h0108_0600, 32'h1);
    wr("unfrz", 32'h0108_0600, 32'h0, 4'hF);
    chk("frozen_0", 32'(frozen_a), 32'd0);
    rd("ch0_unfrozen", 32'h0108_0608, 32'h55);

    // FREEZE and CLEAR together keep pre-clear shadows
    wr("frzclr", 32'h0108_0600, 32'h3, 4'hF);
    rd("ch1_frzclr", 32'h0108_060C, 32'h04);
    rd("ch2_frzclr", 32'h0108_0610, 32'd9);
    rd("ctrl_frzclr", 32'h0108_0600, 32'h1);
    wr("unfrz2", 32'h0108_0600, 32'h0, 4'hF);
    rd("ch1_after", 32'h0108_060C, 32'h0);
    rd("ch2_after", 32'h0108_0610, 32'h0);
    rd("ch0_after", 32'h0108_0608, 32'h55);

    // byte enable gating and unmapped offsets
    wr("be_off", 32'h0108_0600, 32'h1, 4'b1110);
    chk("be_off_frozen", 32'(frozen_a), 32'd0);
    rd("unmapped", 32'h0108_0630, 32'h0);

    // reset in the ack cycle of a CTRL write
    @(posedge clk); #1;
    abus = 32'h0108_0600; rnw_s = 1'b0; dbus_w = 32'h1; be_s = 4'hF; sel = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_ack", 32'(ack), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("rst_mid_drop", 32'(ack), 32'd0);
    sel = 1'b0; rnw_s = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;
    chk("rst_mid_frozen", 32'(frozen_a), 32'd0);
    rd("rst_mid_ctrl", 32'h0108_0600, 32'h0);

    // out of range
    opb_access(32'h0108_0700, 1'b1, 32'h0, 4'hF, d, l, a);
    chk("oor_acks", 32'(a), 32'd0);
    chk("oor_lat", 32'(l), 32'hFFFF_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/opb_status_bank.md
Name: opb_status_bank

Overview:
- Parametrised OPB slave exposing C_NUM_CH status channels from user logic to the PPC. Successor to the single-register simulink-to-PPC status register.
- Each channel accumulates its user input in one of three modes: live, sticky-OR or unsigned peak-hold.
- Software can freeze a coherent snapshot of all channels and clear the accumulators.
- Sits on the OPB next to existing status registers. Single clock domain: user logic is on OPB_Clk.

Parameters:
- C_BASEADDR, 32'h01080600, first byte address of the block
- C_HIGHADDR, 32'h010806FF, last byte address of the block
- C_OPB_AWIDTH, 32, OPB address width
- C_OPB_DWIDTH, 32, OPB data width (fixed 32)
- C_NUM_CH, 8, number of channels (1..32)
- C_CH_WIDTH, 32, bits per channel (1..32)
- C_CH_MODE, all zero, 2*C_NUM_CH-bit vector; bits [2i+1:2i] set channel i mode: 0 live, 1 sticky-OR, 2 peak-max, 3 treated as live
- C_FAMILY, "virtex5", target family

Ports:
- OPB_Clk  in  1  sole clock
- OPB_Rst_n  in  1  asynchronous active-low reset
- Sl_DBus  out  [0:31]  read data
- Sl_errAck  out  1  tied 0
- Sl_retry  out  1  tied 0
- Sl_toutSup  out  1  tied 0
- Sl_xferAck  out  1  transfer acknowledge
- OPB_ABus  in  [0:31]  address
- OPB_BE  in  [0:3]  byte enables
- OPB_DBus  in  [0:31]  write data
- OPB_RNW  in  1  1 = read
- OPB_select  in  1  bus select
- OPB_seqAddr  in  1  ignored
- user_data_in  in  C_NUM_CH*C_CH_WIDTH  channel i at [i*C_CH_WIDTH +: C_CH_WIDTH]
- user_valid  in  C_NUM_CH  per-channel sample strobe
- user_frozen  out  1  mirrors CTRL.FREEZE

Behaviour:
- Reset (async, OPB_Rst_n=0):
  - All outputs 0; acc[], shadow[] and FREEZE cleared.
  - Reset mid-transfer drops Sl_xferAck immediately; no write takes effect.
- Bit numbering: register bit k maps to OPB_DBus[31-k].
- Register map (word offset from C_BASEADDR):
  - 0x00 CTRL R/W: bit0 FREEZE; bit1 CLEAR (write-1 pulse, always reads 0).
  - 0x04 INFO RO: [7:0] C_NUM_CH, [15:8] C_CH_WIDTH, [31:16] 16'h5342.
  - 0x08+4*i CH_i RO: shadow[i] zero-extended to 32 bits.
  - Other in-range offsets: read 0, write ignored, still acked.
- Accumulator, on user_valid[i]:
  - live: acc=data.
  - sticky: acc=acc|data.
  - peak: acc=max(acc,data), unsigned.
  - No user_valid: acc holds.
- CLEAR cycle: the cycle after the acked CTRL write.
  - Sticky/peak acc are zeroed; live acc is unaffected.
  - A user_valid in the CLEAR cycle is applied onto zero, so sticky/peak acc=data.
- Shadow:
  - shadow[i]<=acc[i] every cycle while FREEZE=0.
  - Writing FREEZE=1 stops updates from the cycle after the ack.
  - Writing FREEZE=0 resumes updates on the next cycle.
  - FREEZE and CLEAR written together: the shadow keeps pre-clear values.
- CTRL writes take effect only if OPB_BE[3] is set.
- OPB FSM, states IDLE, ACK, HOLD:
  - IDLE->ACK when OPB_select=1, address within [C_BASEADDR, C_HIGHADDR] and RNW settled.
  - ACK: Sl_xferAck=1 for exactly one cycle; read data is driven on Sl_DBus only in this cycle, otherwise Sl_DBus=0; the write commits on the ACK edge.
  - ACK->HOLD, then HOLD->IDLE.
  - Latency: ack one cycle after select is sampled; back-to-back accesses take 3 cycles each.
  - Out-of-range select: never acked.

Decomposition:
- Package opb_status_bank_pkg holds:
  - register offsets (CTRL, INFO, CH_BASE);
  - mode encodings (MODE_LIVE, MODE_STICKY, MODE_PEAK);
  - INFO ID constant 16'h5342;
  - FSM state typedef.
- One sub-module, status_chan: parameters C_CH_WIDTH and mode; holds acc and shadow; inputs valid, data, clear, freeze. The top generate-instantiates C_NUM_CH copies.
- OPB decode and the FSM stay in the top.

Test Plan:
- Reset, then read INFO at 0x01080604 -> 0x53422008; xferAck high exactly 1 cycle, 1 cycle after select.
- Ch0 live, pulse data 0x11 then 0x22; read 0x01080608 -> 0x22.
- Ch1 sticky, data 0x01 then 0x80 -> 0x81; write CTRL=0x2 -> read 0; same-cycle valid 0x04 with CLEAR -> 0x04.
- Ch2 peak, data 5, 9, 3 -> 9; C_CH_WIDTH=8 with data 0xFF -> read 0x000000FF.
- Write CTRL=0x1, then drive ch0=0x55 -> reads still show the pre-freeze value and user_frozen=1; write CTRL=0 -> 0x55 visible after 1 cycle.
- Assert OPB_Rst_n low during a CTRL write ack cycle -> xferAck drops at once, FREEZE stays 0; select at 0x01080700 -> no ack.
